// File: rtl/sensor_scheduler.sv
// Round-robin ultrasonic scheduler: one shared trigger/echo-timing engine serves NUM_SENSORS sensors.
// Optional SENSOR_SCHED_HOLD_EN keeps a per-sensor last-good distance that is reported on timeouts.

module sensor_echo_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic echo,
  output logic sync,
  output logic prev
);
  logic meta;

  // prev is the previous synchronized value, used for edge detection only
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= echo;
      sync <= meta;
      prev <= sync;
    end
  end
endmodule

module sensor_scheduler #(
  parameter int NUM_SENSORS     = 2,
  parameter int TRIG_CYCLES     = 500,
  parameter int MAX_ECHO_CYCLES = 1900000,
  parameter int GAP_CYCLES      = 3000000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [21:0]            dist_data,
  output logic [1:0]             dist_id,
  output logic                   dist_valid,
  output logic                   dist_timeout,
  output logic                   busy
);
  localparam logic [21:0] TRIG_LAST = 22'(TRIG_CYCLES - 1);
  localparam logic [21:0] ECHO_LAST = 22'(MAX_ECHO_CYCLES - 1);
  // the first high cycle is consumed in WAIT_RISE, so MEASURE reaches the limit one count early
  localparam logic [21:0] MEAS_LAST = 22'(MAX_ECHO_CYCLES - 2);
  localparam logic [21:0] GAP_LAST  = 22'(GAP_CYCLES - 1);
  localparam logic [21:0] MAX_VAL   = 22'(MAX_ECHO_CYCLES);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  typedef struct packed {
    logic        vld;
    logic        to;
    logic [21:0] data;
  } result_t;

  state_t                 state, state_nx;
  logic [21:0]            cnt, cnt_nx;
  logic [1:0]             cur_id, id_nx;
  logic [NUM_SENSORS-1:0] echo_s, echo_p, sel_oh;
  logic                   sel_echo, sel_rise;
  logic [21:0]            to_data;
  result_t                res;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sync
    sensor_echo_sync u_sync (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .echo     (echo[g]),
      .sync     (echo_s[g]),
      .prev     (echo_p[g])
    );
  end

  assign sel_oh   = NUM_SENSORS'(1) << cur_id;
  assign sel_echo = |(echo_s & sel_oh);
  assign sel_rise = sel_echo & ~|(echo_p & sel_oh);
  assign trig     = (state == TRIG) ? sel_oh : '0;
  assign busy     = (state != IDLE);

`ifdef SENSOR_SCHED_HOLD_EN
  logic [NUM_SENSORS-1:0][21:0] last_good;

  always_comb begin
    to_data = '0;
    for (int i = 0; i < NUM_SENSORS; i++)
      if (cur_id == 2'(i)) to_data = last_good[i];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      last_good <= '0;
    end else if (res.vld && !res.to) begin
      for (int i = 0; i < NUM_SENSORS; i++)
        if (cur_id == 2'(i)) last_good[i] <= res.data;
    end
  end
`else
  assign to_data = MAX_VAL;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 22'd1;
    id_nx    = cur_id;
    res.vld  = 1'b0;
    res.to   = 1'b0;
    res.data = cnt + 22'd1;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (enable) state_nx = TRIG;
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_nx = WAIT_RISE;
          cnt_nx   = '0;
        end
      end
      WAIT_RISE: begin
        if (sel_rise) begin
          state_nx = MEASURE;
          cnt_nx   = '0;
        end else if (cnt == ECHO_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
          res.vld  = 1'b1;
          res.to   = 1'b1;
          res.data = to_data;
        end
      end
      MEASURE: begin
        if (!sel_echo) begin
          state_nx = GAP;
          cnt_nx   = '0;
          res.vld  = 1'b1;
        end else if (cnt == MEAS_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
          res.vld  = 1'b1;
          res.to   = 1'b1;
          res.data = to_data;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          id_nx    = (cur_id == 2'(NUM_SENSORS - 1)) ? 2'd0 : cur_id + 2'd1;
          state_nx = enable ? TRIG : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_id       <= '0;
      dist_valid   <= 1'b0;
      dist_data    <= '0;
      dist_id      <= '0;
      dist_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      cur_id     <= id_nx;
      dist_valid <= res.vld;
      if (res.vld) begin
        dist_data    <= res.data;
        dist_id      <= cur_id;
        dist_timeout <= res.to;
      end
    end
  end
endmodule

// File: tb/tb_sensor_scheduler.sv
// Randomized slot-level bench for sensor_scheduler; expected results come from echo width/timing rules.
// Honors SENSOR_SCHED_HOLD_EN when the design is built with it.

module tb_sensor_scheduler;
  localparam int NS = 2, TC = 4, MX = 100, GC = 20;
`ifdef SENSOR_SCHED_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, enable;
  logic [NS-1:0] echo, trig;
  logic [21:0]   dist_data;
  logic [1:0]    dist_id;
  logic          dist_valid, dist_timeout, busy;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, onehot_bad = 0;
  int next_id, prev_vcyc;
  int last_good [NS];

  sensor_scheduler #(
    .NUM_SENSORS(NS), .TRIG_CYCLES(TC), .MAX_ECHO_CYCLES(MX), .GAP_CYCLES(GC)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .enable(enable), .echo(echo), .trig(trig),
    .dist_data(dist_data), .dist_id(dist_id), .dist_valid(dist_valid),
    .dist_timeout(dist_timeout), .busy(busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if ($countones(trig) > 1) onehot_bad <= onehot_bad + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // mode 0: echo of width L starting d clocks after trig falls; 1: no echo; 2: echo already high at WAIT_RISE entry
  task automatic run_slot(input int mode, input int d, input int L, input bit drop_en);
    int t, width, c, fall_cyc, vcyc, exp_data;
    bit got, exp_to, val;
    logic [NS-1:0] oh, nv;
    oh = NS'(1) << next_id;
    t = 0;
    while (trig == '0 && t < 200) begin @(negedge clk); t++; end
    chk("trig_id", trig, oh);
    if (prev_vcyc >= 0) chk("gap_len", cyc - prev_vcyc, GC);
    if (mode == 2) echo = oh;
    width = 0;
    while (trig != '0 && width < 50) begin width++; @(negedge clk); end
    chk("trig_width", width, TC);
    fall_cyc = cyc;
    exp_to   = (mode != 0) || (L >= MX);
    exp_data = exp_to ? (HOLD ? last_good[next_id] : MX) : L;
    got = 1'b0;
    c   = 0;
    vcyc = 0;
    while (!got && c < 400) begin
      case (mode)
        0:       val = (c >= d) && (c < d + L);
        2:       val = (c < 30);
        default: val = 1'b0;
      endcase
      nv   = NS'($urandom);
      echo = (nv & ~oh) | (val ? oh : '0);
      if (drop_en && c == d + 3) enable = 1'b0;
      @(negedge clk);
      c++;
      if (dist_valid) begin got = 1'b1; vcyc = cyc; end
    end
    echo = '0;
    chk("valid_seen", got, 1);
    chk("dist_id", dist_id, next_id);
    chk("dist_timeout", dist_timeout, exp_to);
    chk("dist_data", dist_data, exp_data);
    chk("busy_in_slot", busy, 1);
    if (mode != 0) chk("timeout_latency", vcyc - fall_cyc, MX);
    @(negedge clk);
    chk("valid_pulse", dist_valid, 0);
    chk("data_hold", dist_data, exp_data);
    if (!exp_to) last_good[next_id] = L;
    next_id   = (next_id + 1) % NS;
    prev_vcyc = vcyc;
  endtask

  task automatic reset_model();
    next_id   = 0;
    prev_vcyc = -1;
    for (int i = 0; i < NS; i++) last_good[i] = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_trig"}, trig, 0);
    chk({tag, "_data"}, dist_data, 0);
    chk({tag, "_id"}, dist_id, 0);
    chk({tag, "_valid"}, dist_valid, 0);
    chk({tag, "_timeout"}, dist_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int mode, seen, t;
    rst = 1'b1; enable = 1'b0; echo = '0;
    reset_model();
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy_disabled", busy, 0);
    enable = 1'b1;

    run_slot(0, 10, 37, 0);   // s0 measures 37
    run_slot(1, 0, 0, 0);     // s1 never echoes
    run_slot(0, 5, 150, 0);   // s0 stuck high -> timeout
    run_slot(0, 3, 20, 0);    // s1
    run_slot(0, 2, 42, 0);    // s0 measures 42
    run_slot(2, 0, 0, 0);     // s1 high on entry -> timeout
    run_slot(1, 0, 0, 0);     // s0 timeout, held value 42 when HOLD
    run_slot(0, 7, 99, 0);    // s1 just under the limit
    run_slot(0, 0, 100, 0);   // s0 exactly at the limit
    run_slot(0, 4, 1, 0);     // s1 single-cycle echo
    repeat (16) begin
      mode = $urandom_range(0, 9);
      run_slot(mode < 7 ? 0 : (mode == 7 ? 1 : 2), $urandom_range(0, 90), $urandom_range(1, 150), 0);
    end

    run_slot(0, 5, 30, 1);    // enable drops during MEASURE
    seen = 0;
    repeat (GC + 5) begin
      @(negedge clk);
      if (trig != '0) seen++;
    end
    chk("idle_trig_after_drop", seen, 0);
    chk("idle_busy_after_drop", busy, 0);
    prev_vcyc = -1;

    enable = 1'b1;
    t = 0;
    while (trig == '0 && t < 50) begin @(negedge clk); t++; end
    chk("trig_before_reset", trig != '0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outs("midtrig");
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    run_slot(0, 8, 25, 0);
    run_slot(1, 0, 0, 0);

    chk("trig_onehot", onehot_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
